// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button input block.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        HELD
    } btn_state_t;

    // Counter width for a count of n cycles, never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debouncer and press/long/repeat FSM.
// release_strb / repeat_strb carry those names because release and repeat are SV keywords.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic press,
    output logic release_strb,
    output logic long_press,
    output logic repeat_strb
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int HW = (cnt_width(LONG_CYCLES) > cnt_width(REPEAT_CYCLES)) ?
                        cnt_width(LONG_CYCLES) : cnt_width(REPEAT_CYCLES);

    localparam logic [DW-1:0] DEB_TC  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] LONG_TC = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] REP_TC  = HW'(REPEAT_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          level_q, level_d;
    btn_state_t    state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          repeat_q, repeat_d;
    logic          s, rise, fall;

    assign s    = ~sync_q[1];
    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sync_d  = {sync_q[0], btn_n};
        dcnt_d  = '0;
        level_d = level_q;
        if (s != level_q) begin
            if (dcnt_q == DEB_TC) level_d = ~level_q;
            else                  dcnt_d  = dcnt_q + 1'b1;
        end
    end

    // NOTE: sync flops reset to 1 (released pin level) so reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b11;
            dcnt_q  <= '0;
            level_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all flops sampling pre-edge values.
            sync_q  <= sync_d;
            dcnt_q  <= dcnt_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            hcnt_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
        end
    end

    // The FSM follows level_d so strobes land in the same cycle the level changes.
    always_comb begin
        state_d = state_q;
        hcnt_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (rise) state_d = PRESSED;
            end
            PRESSED: begin
                if (fall)                   state_d = IDLE;
                else if (hcnt_q == LONG_TC) state_d = HELD;
                else                        hcnt_d  = hcnt_q + 1'b1;
            end
            HELD: begin
                if (fall)                   state_d = IDLE;
                else if (hcnt_q != REP_TC)  hcnt_d  = hcnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // A falling level suppresses any coincident long/repeat terminal count.
    always_comb begin
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        unique case (state_q)
            IDLE:    press_d = rise;
            PRESSED: begin
                release_d = fall;
                long_d    = ~fall & (hcnt_q == LONG_TC);
            end
            HELD: begin
                release_d = fall;
                repeat_d  = ~fall & (hcnt_q == REP_TC);
            end
            default: ;
        endcase
    end

    assign level        = level_q;
    assign press        = press_q;
    assign release_strb = release_q;
    assign long_press   = long_q;
    assign repeat_strb  = repeat_q;

endmodule

// File: rtl/button_input.sv
// Board push-button front end: N_BTN independent debounced channels with event strobes.
module button_input
    import btn_pkg::*;
#(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 10_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] release_strb,
    output logic [N_BTN-1:0] long_press,
    output logic [N_BTN-1:0] repeat_strb
);

    if (N_BTN < 1) begin : g_bad_n_btn
        $error("button_input: N_BTN must be >= 1");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("button_input: DEBOUNCE_CYCLES must be >= 2");
    end
    if (LONG_CYCLES < 2) begin : g_bad_long
        $error("button_input: LONG_CYCLES must be >= 2");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_repeat
        $error("button_input: REPEAT_CYCLES must be >= 2");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .btn_n        (btn_n[i]),
            .level        (level[i]),
            .press        (press[i]),
            .release_strb (release_strb[i]),
            .long_press   (long_press[i]),
            .repeat_strb  (repeat_strb[i])
        );
    end

endmodule

// File: tb/tb_button_input.sv
// Scoreboard bench for button_input: stimulus queues expected strobes, a monitor checks every cycle.
module tb_button_input;

    localparam int N   = 3;
    localparam int DEB = 4;
    localparam int LNG = 20;
    localparam int REP = 8;

    typedef enum int {K_PRESS = 0, K_RELEASE = 1, K_LONG = 2, K_REPEAT = 3} kind_t;
    typedef struct {
        int    cyc;
        int    ch;
        kind_t kind;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn_n = '1;
    logic [N-1:0] level, press, release_strb, long_press, repeat_strb;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    button_input #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LNG),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_n        (btn_n),
        .level        (level),
        .press        (press),
        .release_strb (release_strb),
        .long_press   (long_press),
        .repeat_strb  (repeat_strb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic expect_ev(input int c, input int ch, input kind_t k);
        sb.push_back('{cyc: c, ch: ch, kind: k});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic string kname(input int k);
        case (k)
            0:       return "press";
            1:       return "release";
            2:       return "long";
            default: return "repeat";
        endcase
    endfunction

    // Monitor: every strobe bit every cycle must match whether an event was queued for it.
    always @(negedge clk) begin
        logic [N-1:0] got;
        bit           hit;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0:       got = press;
                1:       got = release_strb;
                2:       got = long_press;
                default: got = repeat_strb;
            endcase
            for (int ch = 0; ch < N; ch++) begin
                hit = 1'b0;
                for (int i = 0; i < sb.size(); i++) begin
                    if (sb[i].cyc == cyc && sb[i].ch == ch && int'(sb[i].kind) == k) begin
                        hit = 1'b1;
                        sb.delete(i);
                        break;
                    end
                end
                check($sformatf("%s[%0d]@%0d", kname(k), ch, cyc), {31'd0, got[ch]}, {31'd0, hit});
            end
        end
    end

    initial begin
        int c;
        int r;

        // Reset with all buttons released
        tick(5);
        check("rst_level", {29'd0, level}, 32'd0);
        rst = 1'b0;
        tick(50);
        check("idle_level", {29'd0, level}, 32'd0);

        // ch0 short press: 12 cycles low, no long_press
        c = cyc;
        btn_n[0] = 1'b0;
        expect_ev(c + 6, 0, K_PRESS);
        tick(10);
        check("short_level_up", {29'd0, level}, 32'd1);
        tick(2);
        c = cyc;
        btn_n[0] = 1'b1;
        expect_ev(c + 6, 0, K_RELEASE);
        tick(10);
        check("short_level_down", {29'd0, level}, 32'd0);

        // ch1 glitches of 3 low cycles never survive debounce
        for (int i = 0; i < 10; i++) begin
            btn_n[1] = 1'b0;
            tick(3);
            btn_n[1] = 1'b1;
            tick(1);
        end
        tick(10);
        check("glitch_level", {29'd0, level}, 32'd0);

        // ch2 held 60 cycles: long, repeats, and release beating a repeat terminal count
        c = cyc;
        btn_n[2] = 1'b0;
        expect_ev(c + 6,  2, K_PRESS);
        expect_ev(c + 26, 2, K_LONG);
        expect_ev(c + 34, 2, K_REPEAT);
        expect_ev(c + 42, 2, K_REPEAT);
        expect_ev(c + 50, 2, K_REPEAT);
        expect_ev(c + 58, 2, K_REPEAT);
        tick(30);
        check("held_level", {29'd0, level}, 32'd4);
        tick(30);
        btn_n[2] = 1'b1;
        expect_ev(c + 66, 2, K_RELEASE);
        tick(12);
        check("held_level_down", {29'd0, level}, 32'd0);

        // ch0 level falls exactly on the long terminal cycle: release only
        c = cyc;
        btn_n[0] = 1'b0;
        expect_ev(c + 6,  0, K_PRESS);
        expect_ev(c + 26, 0, K_RELEASE);
        tick(20);
        btn_n[0] = 1'b1;
        tick(12);
        check("long_tie_level", {29'd0, level}, 32'd0);

        // ch0 and ch1 pressed together report in the same cycle
        c = cyc;
        btn_n[1:0] = 2'b00;
        expect_ev(c + 6, 0, K_PRESS);
        expect_ev(c + 6, 1, K_PRESS);
        tick(10);
        check("dual_level", {29'd0, level}, 32'd3);
        btn_n[1:0] = 2'b11;
        expect_ev(c + 16, 0, K_RELEASE);
        expect_ev(c + 16, 1, K_RELEASE);
        tick(12);

        // Reset mid-HELD on ch0 with the button still down
        c = cyc;
        btn_n[0] = 1'b0;
        expect_ev(c + 6,  0, K_PRESS);
        expect_ev(c + 26, 0, K_LONG);
        tick(30);
        rst = 1'b1;
        #1;
        check("mid_rst_level", {29'd0, level}, 32'd0);
        check("mid_rst_strobes",
              {17'd0, press, release_strb, long_press, repeat_strb, 3'd0}, 32'd0);
        tick(3);
        rst = 1'b0;
        r = cyc;
        expect_ev(r + 6, 0, K_PRESS);
        tick(10);
        check("post_rst_level", {29'd0, level}, 32'd1);
        c = cyc;
        btn_n[0] = 1'b1;
        expect_ev(c + 6, 0, K_RELEASE);
        tick(12);
        check("final_level", {29'd0, level}, 32'd0);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
